// File: rtl/unidade_pc.sv
// Program counter with wait/halt FSM and an optional return-address stack.
// Define PILHA_RETORNO_EN to build the return stack; otherwise chamada acts as desvio.
module unidade_pc #(
  parameter int                 LARGURA     = 32,
  parameter logic [LARGURA-1:0] PASSO       = 1,
  parameter logic [LARGURA-1:0] END_INICIAL = '0,
  parameter int                 PROF_PILHA  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               aguarda,
  input  logic               halt,
  input  logic               desvio,
  input  logic [LARGURA-1:0] end_desvio,
  input  logic               chamada,
  input  logic               retorno,
  output logic [LARGURA-1:0] pc,
  output logic [LARGURA-1:0] pc_mais,
  output logic [1:0]         estado,
  output logic               pilha_cheia,
  output logic               pilha_vazia,
  output logic               erro_pilha
);

  typedef enum logic [1:0] {
    EXEC   = 2'b00,
    ESPERA = 2'b01,
    PARADO = 2'b10
  } estado_t;

  estado_t estado_q;
  logic    avanca;

  assign pc_mais = pc + PASSO;
  assign estado  = estado_q;
  assign avanca  = (estado_q == EXEC) && !aguarda && !halt;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= EXEC;
    end else begin
      unique case (estado_q)
        EXEC:    if (halt) estado_q <= PARADO;
                 else if (aguarda) estado_q <= ESPERA;
        ESPERA:  if (halt) estado_q <= PARADO;
                 else if (!aguarda) estado_q <= EXEC;
        default: estado_q <= PARADO;
      endcase
    end
  end

`ifdef PILHA_RETORNO_EN
  localparam int PTR = $clog2(PROF_PILHA);
  localparam logic [PTR:0] CHEIO = (PTR+1)'(PROF_PILHA);

  logic [LARGURA-1:0] pilha [PROF_PILHA];
  logic [PTR:0]       ocupacao;
  logic [PTR:0]       topo;

  assign topo        = ocupacao - 1'b1;
  assign pilha_cheia = (ocupacao == CHEIO);
  assign pilha_vazia = (ocupacao == '0);

  // Retorno wins over chamada; an empty-stack retorno falls back to a sequential step.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= END_INICIAL;
      ocupacao   <= '0;
      erro_pilha <= 1'b0;
    end else begin
      erro_pilha <= 1'b0;
      if (avanca) begin
        if (retorno) begin
          if (pilha_vazia) begin
            pc         <= pc_mais;
            erro_pilha <= 1'b1;
          end else begin
            pc         <= pilha[topo[PTR-1:0]];
            ocupacao   <= topo;
            erro_pilha <= chamada;
          end
        end else if (chamada) begin
          pc <= end_desvio;
          if (pilha_cheia) begin
            erro_pilha <= 1'b1;
          end else begin
            pilha[ocupacao[PTR-1:0]] <= pc_mais;
            ocupacao                 <= ocupacao + 1'b1;
          end
        end else if (desvio) begin
          pc <= end_desvio;
        end else begin
          pc <= pc_mais;
        end
      end
    end
  end
`else
  logic unused_retorno;

  assign unused_retorno = retorno;
  assign pilha_cheia    = 1'b0;
  assign pilha_vazia    = 1'b1;
  assign erro_pilha     = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= END_INICIAL;
    end else if (avanca) begin
      if (chamada || desvio) pc <= end_desvio;
      else                   pc <= pc_mais;
    end
  end
`endif

endmodule
